// File: rtl/imm_narrow_rx.sv
// Toggle-framed word receiver: narrows 32-bit values to 16 bits into a FWFT FIFO.
// Define IMM_NARROW_SYNC_STAGE_EN to add one input register stage ahead of in_q.
module imm_narrow_rx #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [32:0] data_in,
   input  logic        sinal,
   output logic [15:0] out_data,
   output logic        out_ovf,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        full,
   output logic [7:0]  drop_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [33:0]   stage_d;
   logic [33:0]   in_q;
   logic          tog_q;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    drop_q, drop_d;
   logic [16:0]   mem_q [DEPTH];
   logic [16:0]   entry_d;
   logic [16:0]   head;
   logic          ev, fit, push, pop;

`ifdef IMM_NARROW_SYNC_STAGE_EN
   logic [33:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sinal, data_in};
   end

   assign stage_d = sync_q;
`else
   assign stage_d = {sinal, data_in};
`endif

   // in_q[33] carries the mode bit sampled together with its word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q  <= '0;
         tog_q <= 1'b0;
      end else begin
         in_q  <= stage_d;
         tog_q <= in_q[32];
      end
   end

   assign ev  = in_q[32] ^ tog_q;
   assign fit = in_q[33] ? (in_q[31:16] == 16'h0000)
                         : ((&in_q[31:15]) | ~(|in_q[31:15]));
   assign entry_d = {~fit, in_q[15:0]};

   assign out_valid = (count_q != '0);
   assign full      = (count_q == CNT_FULL);
   assign pop       = out_valid & out_ready;
   assign push      = ev & (~full | pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      drop_d  = drop_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (ev && !push && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= entry_d;
   end

   assign head     = mem_q[rptr_q];
   assign out_data = out_valid ? head[15:0] : 16'h0000;
   assign out_ovf  = out_valid & head[16];
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_imm_narrow_rx.sv
// Scoreboard bench for imm_narrow_rx: directed toggle-framed words,
// expected entries queued at issue and checked by a negedge monitor.
module tb_imm_narrow_rx;

`ifdef IMM_NARROW_SYNC_STAGE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [32:0] data_in;
   logic        sinal;
   logic [15:0] out_data;
   logic        out_ovf;
   logic        out_valid;
   logic        out_ready;
   logic        full;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int failures = 0;
   logic tog = 1'b0;
   logic [16:0] expq [$];

   logic [31:0] vw [9] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_7FFF,
                           32'h0000_8000, 32'h0000_8000, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_7FFF};
   logic        vs [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [16:0] ve [9] = '{17'h1_0000, 17'h1_0000, 17'h0_7FFF,
                           17'h1_8000, 17'h0_8000, 17'h1_FFFF,
                           17'h0_FFFF, 17'h0_FFFF, 17'h1_7FFF};

   imm_narrow_rx #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .sinal(sinal),
      .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready), .full(full), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted head word must match the oldest expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected actual=%0h required=none",
                        {out_ovf, out_data});
            end else begin
               logic [16:0] e;
               e = expq.pop_front();
               if ({out_ovf, out_data} !== e) begin
                  failures++;
                  $display("FAIL pop_data actual=%0h required=%0h",
                           {out_ovf, out_data}, e);
               end
            end
         end else if (!out_valid) begin
            checks++;
            if (out_data !== 16'h0 || out_ovf !== 1'b0) begin
               failures++;
               $display("FAIL idle_zero actual=%0h required=0",
                        {out_ovf, out_data});
            end
         end
      end
   end

   task automatic send(input logic [31:0] w, input logic s,
                       input logic expect_en, input logic [16:0] e);
      tog = ~tog;
      data_in = {tog, w};
      sinal = s;
      if (expect_en) expq.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 100 && expq.size() != 0; i++) cyc(1);
      chk("drain_empty", expq.size(), 0);
      cyc(1);
      chk("drain_valid", out_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      data_in = '0;
      sinal = 1'b0;
      out_ready = 1'b0;
      cyc(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_drop", drop_cnt, 0);

      // Word already framed when reset releases
      tog = 1'b1;
      data_in = {1'b1, 32'hFFFF_8000};
      sinal = 1'b0;
      expq.push_back(17'h0_8000);
      @(negedge clk);
      rst = 1'b0;
      cyc(LAT - 1);
      chk("lat_early", out_valid, 0);
      cyc(1);
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 32'h8000);
      chk("lat_ovf", out_ovf, 0);
      drain();

      // Narrowing table, one word per cycle
      for (int i = 0; i < 9; i++) send(vw[i], vs[i], 1'b1, ve[i]);
      drain();

      // Overflow: six events into a 4-deep FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         send(32'h11 + i, 1'b1, i < 4, 17'(32'h11 + i));
      cyc(LAT + 1);
      chk("ovf_full", full, 1);
      chk("ovf_drop", drop_cnt, 2);
      drain();

      // Push into a full FIFO while popping the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(32'hFFFF_FF00 + i, 1'b0, 1'b1, 17'(32'hFF00 + i));
      cyc(LAT + 1);
      chk("pp_full_before", full, 1);
      send(32'h0000_0055, 1'b0, 1'b1, 17'h0_0055);
`ifdef IMM_NARROW_SYNC_STAGE_EN
      cyc(1);
`endif
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      cyc(2);
      chk("pp_full_after", full, 1);
      chk("pp_drop", drop_cnt, 2);
      drain();

      // Toggle held: payload changes must not create events
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = {tog, $urandom};
         sinal = i[0];
         cyc(1);
         chk("hold_valid", out_valid, 0);
      end
      chk("hold_drop", drop_cnt, 2);

      // Reset with entries queued, then a framed word at release
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h100 + i, 1'b1, 1'b0, '0);
      cyc(LAT + 1);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_full", full, 0);
      tog = 1'b1;
      data_in = {1'b1, 32'h0000_1234};
      sinal = 1'b0;
      expq.push_back(17'h0_1234);
      @(negedge clk);
      rst = 1'b0;
      cyc(LAT);
      chk("rel_valid", out_valid, 1);
      chk("rel_data", out_data, 32'h1234);
      drain();
      cyc(5);
      chk("rel_single", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_narrow_rx.md
IMM_NARROW_RX -- requirements
Module: imm_narrow_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_in  input  33  toggle-framed word: [31:0] extended value, [32] toggle flag.
REQ-005 SHALL have port sinal  input  1  narrowing mode: 0 = signed check, 1 = unsigned check.
REQ-006 SHALL have port out_data  output  16  narrowed value at FIFO head.
REQ-007 SHALL have port out_ovf  output  1  head word did not fit in 16 bits.
REQ-008 SHALL have port out_valid  output  1  FIFO head valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head when out_valid is high.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-011 SHALL have port drop_cnt  output  8  count of words lost to a full FIFO, saturating.

Function
REQ-012 SHALL register data_in and sinal into in_q each cycle; toggle reference tog_q SHALL load in_q[32] each cycle.
REQ-013 SHALL detect a word event in any cycle where in_q[32] != tog_q; exactly one event per toggle transition.
REQ-014 Signed mode SHALL mark fit when in_q[31:15] are all equal; unsigned mode SHALL mark fit when in_q[31:16] == 0.
REQ-015 On event SHALL form entry {ovf = ~fit, data = in_q[15:0]}, using the sinal sampled with that word.
REQ-016 Entry SHALL be pushed if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
REQ-017 Otherwise the event SHALL be dropped and drop_cnt incremented, holding at 255.
REQ-018 Pop SHALL occur when out_valid && out_ready; out_data/out_ovf SHALL show head entry (first-word fall-through).
REQ-019 out_data/out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-020 Latency: toggle change stable before edge k SHALL yield out_valid high after edge k+1 (FIFO empty, no macro).
REQ-021 Simultaneous push and pop on an empty FIFO is impossible (out_valid low); on a partially filled FIFO count SHALL be unchanged.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; full = (count == DEPTH); out_valid = (count != 0).
REQ-023 When out_valid is low, out_data and out_ovf SHALL be 0.

Reset
REQ-024 rst SHALL asynchronously clear in_q, tog_q, pointers, count, drop_cnt and all synchronizer stages.
REQ-025 During and after reset, out_valid, full, out_ovf SHALL be 0, out_data 0, drop_cnt 0.
REQ-026 Reset mid-operation SHALL discard FIFO contents and any pending event; if data_in[32] is 1 on release, one event SHALL be seen.

Configuration
REQ-027 Macro IMM_NARROW_SYNC_STAGE_EN defined SHALL insert one extra register stage on all 33 data_in bits plus sinal ahead of in_q (toggle and word kept aligned), latency becomes edge k+2.
REQ-028 Macro IMM_NARROW_SYNC_STAGE_EN undefined SHALL omit that stage; all other behaviour identical.

Verification
REQ-029 Reset, then data_in = {1, 32'hFFFF_8000}, sinal = 0, out_ready = 0 -> after 2 edges out_valid = 1, out_data = 16'h8000, out_ovf = 0.
REQ-030 data_in = {0, 32'h0001_0000}, sinal = 1 -> entry out_data = 16'h0000, out_ovf = 1; same word with sinal = 0 -> out_ovf = 1.
REQ-031 DEPTH = 4, out_ready = 0, 6 toggle events -> full = 1, drop_cnt = 2, pops return first 4 words in order.
REQ-032 FIFO full, out_ready = 1 in the cycle of event 5 -> event 5 accepted, count stays 4, drop_cnt unchanged.
REQ-033 data_in[32] held constant for 20 cycles with changing [31:0] -> no push, out_valid stays 0.
REQ-034 rst pulsed with 3 entries queued -> out_valid = 0, drop_cnt = 0 immediately; with IMM_NARROW_SYNC_STAGE_EN, REQ-029 latency is 3 edges.
